data_memory_ctrl: RTL and testbench

Byte-addressable data memory with a valid/ready request port and a one-cycle response pulse. It supports RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW), with byte-lane write and sign/zero extension. Access latency is programmable, so the block can stall a multi-cycle or pipelined CPU core. Misaligned, illegal-size and out-of-range accesses are detected and reported.

---
 rtl/data_memory_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32I data memory with valid/ready requests, programmable access latency
// and a one-cycle response pulse carrying extended load data and an error flag.
module data_memory_ctrl #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q;
    logic [31:0]      addr_q, wdata_q;
    logic [2:0]       funct3_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             accept, access;

    logic [29:0]      widx;
    logic [1:0]       lane;
    logic [AW-1:0]    idx;
    logic             in_range, bad_op;
    logic [31:0]      rd_word;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic             do_write;
    logic [31:0]      words [MEM_DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                req_ready  = 1'b1;
                resp_valid = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q     <= req_write;
                addr_q   <= addr;
                wdata_q  <= wdata;
                funct3_q <= funct3;
            end
            if (access) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    assign widx     = addr_q[31:2];
    assign lane     = addr_q[1:0];
    assign idx      = widx[AW-1:0];
    assign in_range = ({2'b00, widx} < 32'(MEM_DEPTH));
    assign rd_word  = words[idx];
    assign byte_v   = rd_word[{lane, 3'b000} +: 8];
    assign half_v   = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  bad_op = 1'b0;
            3'b001:  bad_op = lane[0];
            3'b010:  bad_op = |lane;
            3'b100:  bad_op = wr_q;
            3'b101:  bad_op = wr_q | lane[0];
            default: bad_op = 1'b1;
        endcase
        err_d = bad_op | ~in_range;

        rdata_d = '0;
        if (!err_d && !wr_q) begin
            case (funct3_q)
                3'b000:  rdata_d = {{24{byte_v[7]}}, byte_v};
                3'b001:  rdata_d = {{16{half_v[15]}}, half_v};
                3'b010:  rdata_d = rd_word;
                3'b100:  rdata_d = {24'h0, byte_v};
                3'b101:  rdata_d = {16'h0, half_v};
                default: rdata_d = '0;
            endcase
        end

        // Data is replicated across lanes so only the byte enables need the lane offset.
        be       = '0;
        wdata_sh = '0;
        case (funct3_q[1:0])
            2'b00: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be       = 4'b1111;
                wdata_sh = wdata_q;
            end
            default: ;
        endcase
    end

    assign do_write = access & wr_q & ~err_d;

    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_word
        logic [31:0] word_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                word_q <= '0;
            end else if (do_write && idx == AW'(g)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) word_q[8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
        assign words[g] = word_q;
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a LATENCY=1 and a LATENCY=4 instance, with expected
// responses queued at acceptance and compared when resp_valid pulses.
module tb_data_memory_ctrl;

    localparam int unsigned DEPTH = 256;

    logic        clk, reset;
    logic        v1, w1, r1, rv1, e1;
    logic [31:0] a1, d1, rd1;
    logic [2:0]  f1;
    logic        v4, w4, r4, rv4, e4;
    logic [31:0] a4, d4, rd4;
    logic [2:0]  f4;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];

    data_memory_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(r1), .req_write(w1), .addr(a1),
        .wdata(d1), .funct3(f1), .resp_valid(rv1), .rdata(rd1), .err(e1)
    );

    data_memory_ctrl #(.MEM_DEPTH(DEPTH), .LATENCY(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(v4), .req_ready(r4), .req_write(w4), .addr(a4),
        .wdata(d4), .funct3(f4), .resp_valid(rv4), .rdata(rd4), .err(e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        if (sel == 1) begin
            v1 = v; w1 = w; a1 = a; d1 = d; f1 = f;
        end else begin
            v4 = v; w4 = w; a4 = a; d4 = d; f4 = f;
        end
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 1) ? r1 : r4;
    endfunction

    function automatic logic get_rv(input int sel);
        return (sel == 1) ? rv1 : rv4;
    endfunction

    task automatic check_resp(input int sel, input string tag);
        logic [32:0] e;
        e = exp_q.pop_front();
        chk({tag, "_rdata"}, (sel == 1) ? rd1 : rd4, e[32:1]);
        chk1({tag, "_err"}, (sel == 1) ? e1 : e4, e[0]);
    endtask

    task automatic req(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic [31:0] er, input logic ee,
                       input string tag);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d, f);
        n = 0;
        while (!get_rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!get_rdy(sel)) begin
            chk1({tag, "_accept"}, get_rdy(sel), 1'b1);
            drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            return;
        end
        @(posedge clk);
        exp_q.push_back({er, ee});
        #1 drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        chk1({tag, "_busy"}, get_rdy(sel), 1'b0);
        n = 1;
        while (!get_rv(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, (sel == 1) ? 32'd2 : 32'd5);
        if (get_rv(sel)) check_resp(sel, tag);
        else void'(exp_q.pop_front());
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(4, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk1("rst_resp_valid", rv1, 1'b0);
        chk("rst_rdata", rd1, 32'h0);
        chk1("rst_err", e1, 1'b0);
        chk1("rst_ready", r1, 1'b1);
        chk1("rst_ready4", r4, 1'b1);

        req(1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0, 1'b0, "lw0");

        req(1, 1'b1, 32'h10, 32'h11223344, 3'b010, 32'h0, 1'b0, "sw10");
        req(1, 1'b1, 32'h11, 32'h000000AA, 3'b000, 32'h0, 1'b0, "sb11");
        req(1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1122AA44, 1'b0, "lw10");

        req(1, 1'b1, 32'h20, 32'h8001F0FE, 3'b010, 32'h0, 1'b0, "sw20");
        req(1, 1'b0, 32'h20, 32'h0, 3'b000, 32'hFFFFFFFE, 1'b0, "lb20");
        req(1, 1'b0, 32'h20, 32'h0, 3'b100, 32'h000000FE, 1'b0, "lbu20");
        req(1, 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, "lh22");
        req(1, 1'b0, 32'h22, 32'h0, 3'b101, 32'h00008001, 1'b0, "lhu22");

        req(1, 1'b1, 32'h21, 32'h12345678, 3'b010, 32'h0, 1'b1, "sw21_mis");
        req(1, 1'b0, 32'h23, 32'h0, 3'b001, 32'h0, 1'b1, "lh23_mis");
        req(1, 1'b0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1, "f3_011");
        req(1, 1'b0, DEPTH * 4, 32'h0, 3'b010, 32'h0, 1'b1, "lw_oor");
        req(1, 1'b1, 32'h20, 32'h00000000, 3'b100, 32'h0, 1'b1, "sbu_ill");
        req(1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h8001F0FE, 1'b0, "lw20_after");
        @(negedge clk);
        chk1("pulse_width", rv1, 1'b0);
        chk("rdata_hold", rd1, 32'h8001F0FE);

        // Back-to-back on the LATENCY=4 instance with req_valid held high.
        @(negedge clk);
        drive(4, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 3'b010);
        chk1("b2b_ready_a", r4, 1'b1);
        @(posedge clk);
        exp_q.push_back({32'h0, 1'b0});
        #1 drive(4, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r4 && n < 50);
        chk("b2b_gap", n, 32'd5);
        chk1("b2b_resp_a", rv4, 1'b1);
        check_resp(4, "b2b_a");
        @(posedge clk);
        exp_q.push_back({32'hCAFEF00D, 1'b0});
        #1 drive(4, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        chk1("b2b_pulse_a", rv4, 1'b0);
        chk1("b2b_busy_b", r4, 1'b0);
        n = 1;
        while (!rv4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat_b", n, 32'd5);
        if (rv4) check_resp(4, "b2b_b");
        else void'(exp_q.pop_front());
        @(negedge clk);
        chk1("b2b_pulse_b", rv4, 1'b0);

        // Reset two cycles into an in-flight store: no response, no write.
        @(negedge clk);
        drive(4, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 3'b010);
        @(posedge clk);
        #1 drive(4, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv4) seen++;
        end
        chk("rst_drop_resp", seen, 32'd0);
        chk1("rst_drop_ready", r4, 1'b1);
        req(4, 1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 1'b0, "lw40_after_rst");
        req(1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0, "lw10_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
